// File: rtl/dmem_bus.sv
// Data memory for the MIPS memory stage: byte/half/word access, optional wait
// states behind a req/ready handshake, alignment and range faults.
module dmem_bus #(
    parameter int DEPTH       = 64,
    parameter int WAIT_STATES = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [1:0]  size,
    input  logic        uns,
    input  logic [31:0] a,
    input  logic [31:0] wd,
    output logic [31:0] rd,
    output logic        ready,
    output logic        fault,
    output logic        busy
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [3:0] WS_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t      state, state_nx;
    logic [3:0]  cnt, cnt_nx;
    logic        accept, commit;
    logic        fault_q;

    logic        l_we, l_uns;
    logic [1:0]  l_size;
    logic [31:0] l_a, l_wd;

    logic        c_we, c_uns;
    logic [1:0]  c_size;
    logic [31:0] c_a, c_wd;

    logic [1:0]    lane;
    logic [AW-1:0] idx;
    logic          bad;
    logic [3:0]    be;
    logic [31:0]   wdata, word_q, load_v;
    logic [7:0]    byte_v;
    logic [15:0]   half_v;

    logic [31:0] mem [DEPTH];

    assign accept = req && (state == IDLE || state == DONE);
    assign commit = (accept && WAIT_STATES == 0) || (state == BUSY && cnt == 4'd0);

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            IDLE, DONE: begin
                if (accept) begin
                    if (WAIT_STATES == 0) begin
                        state_nx = DONE;
                    end else begin
                        state_nx = BUSY;
                        cnt_nx   = WS_LOAD;
                    end
                end else begin
                    state_nx = IDLE;
                end
            end
            BUSY: begin
                if (cnt == 4'd0) state_nx = DONE;
                else             cnt_nx   = cnt - 4'd1;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Zero-wait accesses commit on the accept edge, before the latch is valid.
    always_comb begin
        if (state == BUSY) begin
            c_we = l_we; c_uns = l_uns; c_size = l_size; c_a = l_a; c_wd = l_wd;
        end else begin
            c_we = we;   c_uns = uns;   c_size = size;   c_a = a;   c_wd = wd;
        end
    end

    always_comb begin
        lane   = c_a[1:0];
        idx    = c_a[AW+1:2];
        word_q = mem[idx];
        bad    = |(c_a >> (AW + 2));
        be     = 4'b0000;
        wdata  = c_wd;
        case (c_size)
            2'b00: begin
                be    = 4'b0001 << lane;
                wdata = {4{c_wd[7:0]}};
            end
            2'b01: begin
                bad   = bad | c_a[0];
                be    = c_a[1] ? 4'b1100 : 4'b0011;
                wdata = {2{c_wd[15:0]}};
            end
            2'b10: begin
                bad = bad | (|c_a[1:0]);
                be  = 4'b1111;
            end
            default: bad = 1'b1;
        endcase
    end

    always_comb begin
        byte_v = word_q[{lane, 3'b000} +: 8];
        half_v = c_a[1] ? word_q[31:16] : word_q[15:0];
        case (c_size)
            2'b00:   load_v = {{24{~c_uns & byte_v[7]}}, byte_v};
            2'b01:   load_v = {{16{~c_uns & half_v[15]}}, half_v};
            default: load_v = word_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset && commit && c_we && !bad) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            l_we   <= we;
            l_uns  <= uns;
            l_size <= size;
            l_a    <= a;
            l_wd   <= wd;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            rd      <= 32'd0;
            fault_q <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            if (commit) begin
                fault_q <= bad;
                if (bad)        rd <= 32'd0;
                else if (!c_we) rd <= load_v;
            end
        end
    end

    assign ready = (state == DONE);
    assign busy  = (state == BUSY);
    assign fault = fault_q & ready;

endmodule

// File: tb/tb_dmem_bus.sv
// Scoreboard bench for dmem_bus: three instances (0, 3 and 2 wait states)
// share the access inputs; each has its own req and reset.
module tb_dmem_bus;

    logic        clk = 1'b0;
    logic [2:0]  rst;
    logic [2:0]  req_v;
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] a, wd;
    logic [31:0] rd_o [3];
    logic [2:0]  ready_o, fault_o, busy_o;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int run0     = 0;
    int max_run0 = 0;

    localparam int WSV [3] = '{0, 3, 2};
    localparam logic [1:0] SZ_B = 2'b00, SZ_H = 2'b01, SZ_W = 2'b10, SZ_X = 2'b11;

    typedef struct {
        string       tag;
        int          inst;
        logic [31:0] rd;
        logic        fault;
        int          cyc;
    } exp_t;

    exp_t        sb [$];
    logic [31:0] last_rd [3];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dmem_bus #(.DEPTH(64), .WAIT_STATES(0)) u_ws0 (
        .clk(clk), .reset(rst[0]), .req(req_v[0]), .we(we), .size(size), .uns(uns),
        .a(a), .wd(wd), .rd(rd_o[0]), .ready(ready_o[0]), .fault(fault_o[0]), .busy(busy_o[0]));
    dmem_bus #(.DEPTH(64), .WAIT_STATES(3)) u_ws3 (
        .clk(clk), .reset(rst[1]), .req(req_v[1]), .we(we), .size(size), .uns(uns),
        .a(a), .wd(wd), .rd(rd_o[1]), .ready(ready_o[1]), .fault(fault_o[1]), .busy(busy_o[1]));
    dmem_bus #(.DEPTH(64), .WAIT_STATES(2)) u_ws2 (
        .clk(clk), .reset(rst[2]), .req(req_v[2]), .we(we), .size(size), .uns(uns),
        .a(a), .wd(wd), .rd(rd_o[2]), .ready(ready_o[2]), .fault(fault_o[2]), .busy(busy_o[2]));

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (ready_o[i]) begin
                if (sb.size() == 0) begin
                    chk_eq($sformatf("spurious_ready%0d", i), 32'(ready_o[i]), 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk_eq({e.tag, "_inst"}, i, e.inst);
                    chk_eq({e.tag, "_fault"}, 32'(fault_o[i]), 32'(e.fault));
                    chk_eq({e.tag, "_rd"}, rd_o[i], e.rd);
                    chk_eq({e.tag, "_latency"}, cyc, e.cyc);
                end
            end else if (fault_o[i]) begin
                chk_eq($sformatf("fault_without_ready%0d", i), 32'(fault_o[i]), 32'd0);
            end
        end
        if (ready_o[0]) run0 = run0 + 1;
        else            run0 = 0;
        if (run0 > max_run0) max_run0 = run0;
    end

    // Drive one access at the falling edge so it is accepted on the next rising edge.
    task automatic issue(input int inst, input string tag, input logic w, input logic [1:0] sz,
                         input logic u, input logic [31:0] addr, input logic [31:0] data,
                         input logic [31:0] erd, input logic ef);
        exp_t e;
        @(negedge clk);
        we = w; size = sz; uns = u; a = addr; wd = data;
        req_v[inst] = 1'b1;
        e.tag   = tag;
        e.inst  = inst;
        e.fault = ef;
        e.rd    = ef ? 32'd0 : (w ? last_rd[inst] : erd);
        e.cyc   = cyc + 1 + WSV[inst];
        last_rd[inst] = e.rd;
        sb.push_back(e);
        @(posedge clk);
        #1;
        req_v = 3'b000;
        we = 1'b0; a = 32'hFFFF_FFFF; wd = 32'h5A5A_5A5A;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            chk_eq("drain_timeout", sb.size(), 32'd0);
            sb.delete();
        end
    endtask

    initial begin
        rst = 3'b111; req_v = 3'b000; we = 1'b0; size = SZ_W; uns = 1'b0; a = '0; wd = '0;
        for (int i = 0; i < 3; i++) last_rd[i] = 32'd0;
        repeat (3) @(posedge clk);
        #1 rst = 3'b000;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk_eq($sformatf("reset_ready%0d", i), 32'(ready_o[i]), 32'd0);
            chk_eq($sformatf("reset_fault%0d", i), 32'(fault_o[i]), 32'd0);
            chk_eq($sformatf("reset_busy%0d", i),  32'(busy_o[i]),  32'd0);
            chk_eq($sformatf("reset_rd%0d", i),    rd_o[i],         32'd0);
        end

        // Word, byte and halfword stores with sub-word loads, no wait states.
        issue(0, "st_w10",  1'b1, SZ_W, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0); drain();
        issue(0, "ld_w10",  1'b0, SZ_W, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0); drain();
        issue(0, "st_b11",  1'b1, SZ_B, 1'b0, 32'h11, 32'h000000A5, 32'h0, 1'b0); drain();
        issue(0, "ld_w10b", 1'b0, SZ_W, 1'b0, 32'h10, 32'h0, 32'hDEADA5EF, 1'b0); drain();
        issue(0, "ld_bs11", 1'b0, SZ_B, 1'b0, 32'h11, 32'h0, 32'hFFFFFFA5, 1'b0); drain();
        issue(0, "ld_bu11", 1'b0, SZ_B, 1'b1, 32'h11, 32'h0, 32'h000000A5, 1'b0); drain();
        issue(0, "ld_hs12", 1'b0, SZ_H, 1'b0, 32'h12, 32'h0, 32'hFFFFDEAD, 1'b0); drain();
        issue(0, "ld_hu12", 1'b0, SZ_H, 1'b1, 32'h12, 32'h0, 32'h0000DEAD, 1'b0); drain();
        issue(0, "st_h12",  1'b1, SZ_H, 1'b0, 32'h12, 32'hFFFF1234, 32'h0, 1'b0); drain();
        issue(0, "ld_w10c", 1'b0, SZ_W, 1'b0, 32'h10, 32'h0, 32'h1234A5EF, 1'b0); drain();
        issue(0, "ld_bs13", 1'b0, SZ_B, 1'b0, 32'h13, 32'h0, 32'h00000012, 1'b0); drain();
        issue(0, "flt_h13", 1'b0, SZ_H, 1'b0, 32'h13, 32'h0, 32'h0, 1'b1); drain();

        // Back-to-back stores with req held, then back-to-back readback.
        @(negedge clk);
        max_run0 = 0;
        for (int k = 0; k < 4; k++)
            issue(0, $sformatf("b2b_st%0d", k), 1'b1, SZ_W, 1'b0, 32'(4 * k),
                  32'(32'h1111_1111 * (k + 1)), 32'h0, 1'b0);
        drain();
        chk_eq("b2b_ready_run", max_run0, 32'd4);
        for (int k = 0; k < 4; k++)
            issue(0, $sformatf("b2b_ld%0d", k), 1'b0, SZ_W, 1'b0, 32'(4 * k), 32'h0,
                  32'(32'h1111_1111 * (k + 1)), 1'b0);
        drain();

        // Faults leave word 0 untouched.
        issue(0, "flt_st102", 1'b1, SZ_W, 1'b0, 32'h102, 32'hBAD0BAD0, 32'h0, 1'b1); drain();
        issue(0, "flt_ld100", 1'b0, SZ_W, 1'b0, 32'h100, 32'h0, 32'h0, 1'b1); drain();
        issue(0, "flt_sz11",  1'b0, SZ_X, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1); drain();
        issue(0, "flt_st_hi", 1'b1, SZ_B, 1'b0, 32'h8000_0000, 32'hEE, 32'h0, 1'b1); drain();
        issue(0, "ld_w0",     1'b0, SZ_W, 1'b0, 32'h0, 32'h0, 32'h11111111, 1'b0); drain();

        // Wait states: busy for three cycles, single ready, req while busy ignored.
        issue(1, "ws_st40", 1'b1, SZ_W, 1'b0, 32'h40, 32'h0BADCAFE, 32'h0, 1'b0); drain();
        issue(1, "ws_st44", 1'b1, SZ_W, 1'b0, 32'h44, 32'h600DF00D, 32'h0, 1'b0); drain();
        issue(1, "ws_ld40", 1'b0, SZ_W, 1'b0, 32'h40, 32'h0, 32'h0BADCAFE, 1'b0);
        @(negedge clk);
        chk_eq("ws_busy_t1",  32'(busy_o[1]),  32'd1);
        chk_eq("ws_ready_t1", 32'(ready_o[1]), 32'd0);
        @(negedge clk);
        chk_eq("ws_busy_t2",  32'(busy_o[1]),  32'd1);
        chk_eq("ws_ready_t2", 32'(ready_o[1]), 32'd0);
        we = 1'b1; size = SZ_W; a = 32'h44; wd = 32'hFFFFFFFF; req_v[1] = 1'b1;
        @(posedge clk);
        #1 req_v[1] = 1'b0;
        @(negedge clk);
        chk_eq("ws_busy_t3",  32'(busy_o[1]),  32'd1);
        chk_eq("ws_ready_t3", 32'(ready_o[1]), 32'd0);
        @(negedge clk);
        chk_eq("ws_busy_t4",  32'(busy_o[1]),  32'd0);
        chk_eq("ws_ready_t4", 32'(ready_o[1]), 32'd1);
        @(negedge clk);
        chk_eq("ws_ready_t5", 32'(ready_o[1]), 32'd0);
        drain();
        repeat (5) @(negedge clk);
        issue(1, "ws_ld44", 1'b0, SZ_W, 1'b0, 32'h44, 32'h0, 32'h600DF00D, 1'b0); drain();

        // Reset in the first busy cycle aborts a store.
        issue(2, "ra_st20", 1'b1, SZ_W, 1'b0, 32'h20, 32'hCAFEF00D, 32'h0, 1'b0); drain();
        issue(2, "ra_ld20", 1'b0, SZ_W, 1'b0, 32'h20, 32'h0, 32'hCAFEF00D, 1'b0); drain();
        @(negedge clk);
        we = 1'b1; size = SZ_W; a = 32'h20; wd = 32'h12345678; req_v[2] = 1'b1;
        @(posedge clk);
        #1 req_v[2] = 1'b0;
        @(negedge clk);
        chk_eq("ra_busy_pre", 32'(busy_o[2]), 32'd1);
        rst[2] = 1'b1;
        @(posedge clk);
        #1 rst[2] = 1'b0;
        last_rd[2] = 32'd0;
        @(negedge clk);
        chk_eq("ra_ready", 32'(ready_o[2]), 32'd0);
        chk_eq("ra_busy",  32'(busy_o[2]),  32'd0);
        chk_eq("ra_rd",    rd_o[2],         32'd0);
        repeat (5) @(negedge clk);
        issue(2, "ra_ld20b", 1'b0, SZ_W, 1'b0, 32'h20, 32'h0, 32'hCAFEF00D, 1'b0); drain();

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, checks=%0d", checks);
        $fatal(1, "timeout");
    end

endmodule
